// File: rtl/codec_pkg.sv
// codec_pkg: shared constants and the receiver state type for the codec
// sample path.
package codec_pkg;

   // Default delivered sample width.
   localparam int DATA_W_DEF = 16;

   // Width of the optional discarded-word counter.
   localparam int ERR_CNT_W = 8;

   // Receiver word-framing states.
   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      SHIFT,
      WAIT_LR
   } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for one asynchronous line, plus
// single-cycle rise/fall pulses taken from the last stage and its delayed copy.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   // Synchroniser chain and one-cycle delayed copy of its output.
   // NOTE: every flop, including the synchroniser chain, is cleared by the
   // asynchronous reset so edge detection starts from a known level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep each stage sampling the
         // previous stage's old value, forming a real shift chain.
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
   assign rise = dout & ~dly_q;
   assign fall = ~dout & dly_q;

endmodule

// File: rtl/codec_sample_rx.sv
// codec_sample_rx: I2S stereo receiver. Oversamples BCLK/LRCLK/SDATA on clk,
// assembles MSB-first words into 16-bit left/right samples and emits a
// VALID strobe of VALID_WIDTH cycles per complete left/right frame.
// Optional build macro CODEC_RX_ERR_CNT_EN adds the saturating err_cnt port.
module codec_sample_rx
   import codec_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int VALID_WIDTH = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              BCLK,
   input  logic              LRCLK,
   input  logic              SDATA,
   output logic              VALID,
   output logic [DATA_W-1:0] left_in,
   output logic [DATA_W-1:0] right_in,
   output logic              frame_err
`ifdef CODEC_RX_ERR_CNT_EN
  ,output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int VCNT_W = 4;

   // Synchronised lines and edge pulses.
   logic bclk_lvl, bclk_rise, bclk_fall;
   logic lr_lvl, lr_rise, lr_fall, lr_edge;
   logic sdata_s, sd_rise, sd_fall;
   logic unused_sync;

   // Framing state and datapath.
   rx_state_t          state_q, state_d;
   logic               shift_en, cnt_clr, store_word, discard;
   logic [CNT_W-1:0]   bit_cnt;
   logic [DATA_W-1:0]  shreg, l_hold, r_hold;
   logic               left_ok, out_load;
   logic [VCNT_W-1:0]  vcnt;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (BCLK),
      .dout (bclk_lvl),
      .rise (bclk_rise),
      .fall (bclk_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (LRCLK),
      .dout (lr_lvl),
      .rise (lr_rise),
      .fall (lr_fall)
   );

   // SDATA only needs the synchronised level; its pulses go unused.
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdata_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (SDATA),
      .dout (sdata_s),
      .rise (sd_rise),
      .fall (sd_fall)
   );

   assign unused_sync = ^{bclk_lvl, bclk_fall, sd_rise, sd_fall};
   assign lr_edge     = lr_rise | lr_fall;

   // Framing state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and per-cycle control. An lr_edge always wins over a
   // coincident bclk_rise; that rise is then consumed as the I2S skip bit,
   // so the FSM lands directly in SHIFT.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned and no latch is inferred.
      state_d    = state_q;
      shift_en   = 1'b0;
      cnt_clr    = 1'b0;
      store_word = 1'b0;
      discard    = 1'b0;
      case (state_q)
         IDLE: begin
            if (lr_fall) begin
               cnt_clr = 1'b1;
               state_d = bclk_rise ? SHIFT : ALIGN;
            end
         end
         ALIGN: begin
            if (lr_edge) begin
               // A word boundary before any data bit is an empty word.
               discard = 1'b1;
               cnt_clr = 1'b1;
               state_d = bclk_rise ? SHIFT : ALIGN;
            end else if (bclk_rise) begin
               cnt_clr = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (lr_edge) begin
               discard = 1'b1;
               cnt_clr = 1'b1;
               state_d = bclk_rise ? SHIFT : ALIGN;
            end else if (bclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == CNT_W'(DATA_W - 1)) state_d = WAIT_LR;
            end
         end
         WAIT_LR: begin
            if (lr_edge) begin
               store_word = 1'b1;
               cnt_clr    = 1'b1;
               state_d    = bclk_rise ? SHIFT : ALIGN;
            end
         end
      endcase
   end

   // Word assembly, left/right hold registers and frame bookkeeping.
   // On a stored word the new LRCLK level is the opposite of the finished
   // word's: a rising edge closes a left word, a falling edge a right word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         l_hold    <= '0;
         r_hold    <= '0;
         left_ok   <= 1'b0;
         out_load  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (cnt_clr)       bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

         if (shift_en) shreg <= {shreg[DATA_W-2:0], sdata_s};

         if (store_word &&  lr_lvl) l_hold <= shreg;
         if (store_word && !lr_lvl) r_hold <= shreg;

         // A frame is publishable only if its left word arrived intact.
         if (discard)         left_ok <= 1'b0;
         else if (store_word) left_ok <= lr_lvl;

         out_load  <= store_word & ~lr_lvl & left_ok;
         frame_err <= discard;
      end
   end

   // Output samples and VALID pulse stretcher; a new frame restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         VALID    <= 1'b0;
         vcnt     <= '0;
         left_in  <= '0;
         right_in <= '0;
      end else if (out_load) begin
         VALID    <= 1'b1;
         vcnt     <= VCNT_W'(VALID_WIDTH - 1);
         left_in  <= l_hold;
         right_in <= r_hold;
      end else if (VALID) begin
         if (vcnt == '0) VALID <= 1'b0;
         else            vcnt  <= vcnt - 1'b1;
      end
   end

`ifdef CODEC_RX_ERR_CNT_EN
   // Saturating count of discarded words, steps with each frame_err pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       err_cnt <= '0;
      else if (discard && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
   end
`else
   // Without the counter, frame_err is the only discard indication.
`endif

endmodule

// File: tb/tb_codec_sample_rx.sv
// tb_codec_sample_rx: drives an I2S stream (LRCLK/SDATA change on BCLK fall,
// one-bit delay) and checks codec_sample_rx against a word-level model.
// Build with CODEC_RX_ERR_CNT_EN defined to also exercise err_cnt.
module tb_codec_sample_rx;

  localparam int DATA_W = 16;
  localparam int VW     = 4;
  localparam int SS     = 2;
  localparam int LAT    = SS + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic BCLK = 1'b0;
  logic LRCLK = 1'b1;
  logic SDATA = 1'b0;
  logic VALID, frame_err;
  logic [DATA_W-1:0] left_in, right_in;
`ifdef CODEC_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  frame_t fq[$];
  int     eq[$];

  // word-level model state
  logic        prev_lr;
  logic        armed;
  logic        left_ok;
  logic        carry;
  logic [15:0] m_l;
  int          cur_w;
  logic [31:0] cur_data;

  // observation of the DUT
  int   last_fall_cyc  = 0;
  int   last_vrise_cyc = 0;
  int   dut_vrise      = 0;
  int   dut_errs       = 0;
  logic v_prev         = 1'b0;

  // expectations driven by the model queues
  logic [15:0] exp_l    = '0;
  logic [15:0] exp_r    = '0;
  int          exp_vend = -1;
  logic        exp_err;
  logic [7:0]  exp_ec   = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  codec_sample_rx #(
    .DATA_W     (DATA_W),
    .VALID_WIDTH(VW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .BCLK     (BCLK),
    .LRCLK    (LRCLK),
    .SDATA    (SDATA),
    .VALID    (VALID),
    .left_in  (left_in),
    .right_in (right_in),
    .frame_err(frame_err)
`ifdef CODEC_RX_ERR_CNT_EN
   ,.err_cnt  (err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    eq.delete();
    armed   = 1'b0;
    left_ok = 1'b0;
    prev_lr = LRCLK;
  endtask

  // Judge the word that has just ended on an LRCLK change.
  task automatic finish_word(input logic lr);
    frame_t f;
    if (cur_w - 1 >= DATA_W) begin
      if (!lr) begin
        m_l     = cur_data[31:16];
        left_ok = 1'b1;
      end else begin
        if (left_ok) begin
          f.due = cyc + LAT;
          f.l   = m_l;
          f.r   = cur_data[31:16];
          fq.push_back(f);
        end
        left_ok = 1'b0;
      end
    end else begin
      eq.push_back(cyc + SS + 1);
      left_ok = 1'b0;
    end
  endtask

  task automatic model_edge(input logic lr, input int w, input logic [31:0] data);
    if (lr !== prev_lr) begin
      if (armed) finish_word(prev_lr);
      if (prev_lr && !lr) begin
        armed         = 1'b1;
        last_fall_cyc = cyc;
      end
      prev_lr = lr;
    end
    cur_w    = w;
    cur_data = data;
  endtask

  // One codec word of w BCLK slots; slot 0 carries the previous word's last
  // bit, slots 1..w-1 carry data MSB first. Optional reset in slot rst_slot.
  task automatic send(input logic lr, input int w, input logic [31:0] data,
                      input int half = 8, input int rst_slot = -1);
    for (int s = 0; s < w; s++) begin
      @(negedge clk);
      BCLK = 1'b0;
      if (s == 0) begin
        LRCLK = lr;
        model_edge(lr, w, data);
        SDATA = carry;
      end else begin
        SDATA = data[32-s];
      end
      repeat (half) @(negedge clk);
      BCLK = 1'b1;
      for (int k = 0; k < half - 1; k++) begin
        @(negedge clk);
        if (s == rst_slot && k == 0) begin
          rst_n = 1'b0;
          model_reset();
          #1;
          check("mid_rst_valid", 32'(VALID), 32'd0);
          check("mid_rst_left", 32'(left_in), 32'd0);
          check("mid_rst_right", 32'(right_in), 32'd0);
          check("mid_rst_ferr", 32'(frame_err), 32'd0);
        end
        if (s == rst_slot && k == 2) rst_n = 1'b1;
      end
    end
    carry = data[32-w];
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      exp_err = 1'b0;
      if (!rst_n) begin
        exp_l    = '0;
        exp_r    = '0;
        exp_vend = -1;
        exp_ec   = '0;
      end else begin
        if (fq.size() > 0 && fq[0].due == cyc) begin
          exp_l    = fq[0].l;
          exp_r    = fq[0].r;
          exp_vend = cyc + VW - 1;
          void'(fq.pop_front());
        end
        if (eq.size() > 0 && eq[0] == cyc) begin
          exp_err = 1'b1;
          void'(eq.pop_front());
          if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
        end
      end
      check("valid", 32'(VALID), 32'(cyc <= exp_vend));
      check("left_in", 32'(left_in), 32'(exp_l));
      check("right_in", 32'(right_in), 32'(exp_r));
      check("frame_err", 32'(frame_err), 32'(exp_err));
`ifdef CODEC_RX_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt), 32'(exp_ec));
`endif
      if (VALID && !v_prev) begin
        dut_vrise++;
        last_vrise_cyc = cyc;
      end
      if (frame_err) dut_errs++;
      v_prev = VALID;
    end
  end

  initial begin
    int lens[8];
    lens  = '{10, 16, 17, 20, 24, 32, 32, 32};
    carry = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_left", 32'(left_in), 32'd0);
    check("rst_right", 32'(right_in), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // stream starts in the middle of a right word
    send(1'b1, 20, $urandom);
    send(1'b0, 32, {16'h1234, 16'h0F0F});
    send(1'b1, 32, {16'hFEDC, 16'hA5A5});
    check("no_valid_before_frame", 32'(dut_vrise), 32'd0);
    send(1'b0, 32, {16'h8000, 16'h1111});
    check("t1_left", 32'(left_in), 32'h1234);
    check("t1_right", 32'(right_in), 32'hFEDC);
    check("t1_vcount", 32'(dut_vrise), 32'd1);
    check("t1_no_err", 32'(dut_errs), 32'd0);

    // three back-to-back frames with latency pinned
    send(1'b1, 32, {16'h8001, 16'h2222});
    send(1'b0, 32, {16'h8002, 16'h3333});
    check("t2_lat1", 32'(last_vrise_cyc - last_fall_cyc), 32'(LAT));
    check("t2_f1", {left_in, right_in}, 32'h8000_8001);
    send(1'b1, 32, {16'h8003, 16'h4444});
    send(1'b0, 32, {16'h7FFF, 16'h5555});
    check("t2_lat2", 32'(last_vrise_cyc - last_fall_cyc), 32'(LAT));
    check("t2_f2", {left_in, right_in}, 32'h8002_8003);
    send(1'b1, 32, {16'h8000, 16'h6666});

    // left word cut to 10 slots
    send(1'b0, 10, {16'hDEAD, 16'hBEEF});
    check("t2_lat3", 32'(last_vrise_cyc - last_fall_cyc), 32'(LAT));
    check("t2_f3", {left_in, right_in}, 32'h7FFF_8000);
    check("t2_vcount", 32'(dut_vrise), 32'd4);
    send(1'b1, 32, {16'h1111, 16'h0000});
    send(1'b0, 32, {16'hA5A5, 16'h0000});
    check("short_err_once", 32'(dut_errs), 32'd1);
    check("short_no_valid", 32'(dut_vrise), 32'd4);
    check("short_hold", {left_in, right_in}, 32'h7FFF_8000);
    send(1'b1, 32, {16'h5A5A, 16'h0000});
    send(1'b0, 17, {16'hC3C3, 16'h0000});
    check("recover", {left_in, right_in}, 32'hA5A5_5A5A);

    // exact-length words (DATA_W+1 slots) then a one-slot-short right word
    send(1'b1, 17, {16'h3C3C, 16'h0000});
    send(1'b0, 32, {16'h0F0F, 16'h0000});
    check("exact_len", {left_in, right_in}, 32'hC3C3_3C3C);
    send(1'b1, 16, {16'h9999, 16'h0000});
    send(1'b0, 32, {16'h4321, 16'h0000});
    check("len16_err", 32'(dut_errs), 32'd2);
    check("len16_hold", {left_in, right_in}, 32'hC3C3_3C3C);

    // reset while shifting bit 7 of a left word
    send(1'b1, 32, {16'h6666, 16'h0000});
    send(1'b0, 32, {16'h7777, 16'h0000}, 8, 8);
    send(1'b1, 32, {16'h9999, 16'h0000});
    send(1'b0, 32, {16'hABCD, 16'h0000});
    send(1'b1, 32, {16'h1357, 16'h0000});
    send(1'b0, 32, {16'h2468, 16'h0000});
    check("after_reset", {left_in, right_in}, 32'hABCD_1357);

    // randomized frames, lengths and BCLK ratios
    for (int i = 0; i < 30; i++) begin
      send(1'b1, lens[$urandom_range(0, 7)], $urandom, $urandom_range(4, 8));
      send(1'b0, lens[$urandom_range(0, 7)], $urandom, $urandom_range(4, 8));
    end

`ifdef CODEC_RX_ERR_CNT_EN
    for (int i = 0; i < 300; i++) send(i[0] ? 1'b0 : 1'b1, 10, $urandom, 4);
    send(1'b1, 32, $urandom, 4);
    repeat (10) @(negedge clk);
    #1;
    check("err_cnt_sat", 32'(err_cnt), 32'h0000_00FF);
`endif

    send(1'b1, 32, $urandom);
    send(1'b0, 32, $urandom);
    repeat (20) @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
